// File: rtl/fsm_proc_periph_hs.sv
// -----------------------------------------------------------------------------
// fsm_proc_periph_hs
//   Processor-side handshake controller. Accepts one command at a time from the
//   processor (valid/ready), then runs a 4-phase req/ack handshake with the
//   selected peripheral and reports completion, errors and a transfer count.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   cmd_valid  : processor command valid
//   cmd_ready  : controller can accept a command (combinational: IDLE && rst)
//   cmd_dest   : target peripheral index
//   cmd_data   : payload
//   per_req    : one-hot request to the peripherals (at most one bit high)
//   per_ack    : per-peripheral acknowledge, synchronous to clk
//   per_data   : shared payload bus, valid while any per_req bit is high
//   busy       : high in any state other than IDLE
//   done       : one-cycle pulse on handshake completion
//   err        : one-cycle pulse on a bad destination (or a watchdog timeout)
//   xfer_cnt   : count of completed transfers, wraps 0xFFFF -> 0
//
// Build option
//   FSM_PROC_PERIPH_TIMEOUT_EN : when defined, a per-phase watchdog aborts a
//   REQ or REL phase that lasts TIMEOUT_CYC cycles without the awaited ack.
// -----------------------------------------------------------------------------
module fsm_proc_periph_hs #(
    parameter int NUM_PERIPH  = 2,
    parameter int DEST_W      = 1,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DEST_W-1:0]     cmd_dest,
    input  logic [DATA_W-1:0]     cmd_data,
    output logic [NUM_PERIPH-1:0] per_req,
    input  logic [NUM_PERIPH-1:0] per_ack,
    output logic [DATA_W-1:0]     per_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           xfer_cnt
);

    if (NUM_PERIPH < 1 || NUM_PERIPH > (1 << DEST_W)) begin : g_bad_num_periph
        $error("NUM_PERIPH must be in 1..2**DEST_W");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_PERIPH-1:0] sel_q, sel_d;       // one-hot copy of the latched dest
    logic [NUM_PERIPH-1:0] per_req_q, per_req_d;
    logic [DATA_W-1:0]     per_data_q, per_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           xfer_cnt_q, xfer_cnt_d;

    logic [NUM_PERIPH-1:0] dest_oh;
    logic                  dest_bad;
    logic                  ack_sel;

`ifdef FSM_PROC_PERIPH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] phase_q, phase_d;
`endif

    // Decode the incoming destination; out-of-range indices produce no bit.
    always_comb begin
        dest_oh = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (32'(cmd_dest) == 32'(i)) dest_oh[i] = 1'b1;
        end
    end

    assign dest_bad = (32'(cmd_dest) >= 32'(NUM_PERIPH));

    // Only the selected channel's ack is ever looked at.
    assign ack_sel = |(per_ack & sel_q);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        per_req_d  = per_req_q;
        per_data_d = per_data_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        xfer_cnt_d = xfer_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (dest_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        sel_d      = dest_oh;
                        per_req_d  = dest_oh;
                        per_data_d = cmd_data;
                    end
                end
            end
            S_REQ: begin
                if (ack_sel) begin
                    state_d   = S_REL;
                    per_req_d = '0;
                end
            end
            S_REL: begin
                if (!ack_sel) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                sel_d      = '0;
                per_data_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef FSM_PROC_PERIPH_TIMEOUT_EN
        // Phase counter is zero on entry to REQ (IDLE holds it at zero) and is
        // re-zeroed on the REQ->REL step; an expired phase overrides the case.
        phase_d = '0;
        if (state_q == S_REQ || state_q == S_REL) begin
            if (state_d != state_q) begin
                phase_d = '0;
            end else if (phase_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d    = S_IDLE;
                sel_d      = '0;
                per_req_d  = '0;
                per_data_d = '0;
                err_d      = 1'b1;
            end else begin
                phase_d = phase_q + CNT_W'(1);
            end
        end
`endif

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            per_req_q  <= '0;
            per_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            per_req_q  <= per_req_d;
            per_data_q <= per_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

`ifdef FSM_PROC_PERIPH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) phase_q <= '0;
        else      phase_q <= phase_d;
    end
`endif

    // cmd_ready is the only combinational output; it drops with rst at once.
    assign cmd_ready = (state_q == S_IDLE) && rst;
    assign per_req   = per_req_q;
    assign per_data  = per_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: doc/fsm_proc_periph_hs.md
Name: fsm_proc_periph_hs

Overview:
- Processor-side handshake controller: the next generation of the processor/peripheral FSM pair, generalised to NUM_PERIPH peripherals and DATA_W-bit payloads.
- Accepts one command at a time from the processor (valid/ready), then runs a 4-phase req/ack handshake with the selected peripheral.
- Reports completion, errors and a running transfer count.

Parameters:
- NUM_PERIPH, 2, number of peripheral channels (1..2**DEST_W).
- DEST_W, 1, width of the destination select.
- DATA_W, 8, payload width.
- TIMEOUT_CYC, 15, watchdog limit in cycles per handshake phase (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  processor command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_dest  in  DEST_W  target peripheral index.
- cmd_data  in  DATA_W  payload.
- per_req  out  NUM_PERIPH  one-hot request; at most one bit high.
- per_ack  in  NUM_PERIPH  per-peripheral acknowledge, synchronous to clk.
- per_data  out  DATA_W  shared payload bus, valid while any per_req bit is high.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on handshake completion.
- err  out  1  one-cycle pulse on a bad destination or a timeout.
- xfer_cnt  out  16  count of completed transfers; wraps 0xFFFF->0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; per_req=0, per_data=0, busy=0, done=0, err=0, xfer_cnt=0; cmd_ready forced 0 while rst=0.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE) && rst.
- States:
  - IDLE -> REQ, or -> IDLE with err.
  - REQ -> REL.
  - REL -> DONE.
  - DONE -> IDLE.
- IDLE: a command is accepted on an edge with cmd_valid && cmd_ready.
  - If cmd_dest >= NUM_PERIPH: err=1 for the next cycle, stay IDLE, no request issued.
  - Otherwise latch dest/data; next cycle state=REQ, per_req[dest]=1, per_data=data, busy=1.
- REQ: hold the request until per_ack[dest]=1 is sampled; then state=REL, per_req=0 in the same edge. per_data holds its value until DONE.
- REL: wait for per_ack[dest]=0; then state=DONE.
- DONE: done=1 for exactly one cycle; xfer_cnt increments; next edge -> IDLE; per_data cleared to 0.
- Ack handling:
  - per_ack bits of non-selected channels are ignored in every state.
  - An ack already high on entry to REQ counts on the first REQ edge.
- Minimum latency with a peripheral whose ack follows req by one cycle: accept edge to cmd_ready re-high = 5 cycles.
- cmd_valid while busy: ignored, with no side effects; the processor must hold the command until accepted.
- Reset asserted mid-transaction: immediate abort to IDLE with all outputs cleared; xfer_cnt is not incremented.

Optional Feature:
- Macro: FSM_PROC_PERIPH_TIMEOUT_EN.
- Defined:
  - A phase counter clears on entry to REQ and again on entry to REL, and counts each cycle spent in that state.
  - Reaching TIMEOUT_CYC without the awaited ack transition aborts: per_req=0, err=1 for one cycle, state -> IDLE.
  - No done pulse and no xfer_cnt increment on abort.
- Undefined:
  - No counter logic; REQ/REL wait indefinitely.
  - err is raised only for a bad destination.

Test Plan:
- Reset, then cmd dest=1, data=0xA5; peripheral 1 acks 1 cycle after req and drops ack 1 cycle after req falls -> per_req=2'b10 with per_data=0xA5; done pulses once; xfer_cnt=1; cmd_ready back high 5 cycles after accept.
- Back-to-back cmds dest=0 data=0x11, then dest=1 data=0x22 -> two sequential handshakes, never both per_req bits high; xfer_cnt=2.
- With NUM_PERIPH=3, DEST_W=2, cmd dest=3 -> err pulse 1 cycle after accept; per_req stays 0; xfer_cnt unchanged; cmd_ready stays 1.
- Ack on the non-selected channel 0 while dest=1 is in REQ -> no state change until per_ack[1] rises.
- rst pulled low while in REQ -> per_req=0, busy=0 immediately (before the next clk edge); after release cmd_ready=1, xfer_cnt unchanged.
- FSM_PROC_PERIPH_TIMEOUT_EN defined, TIMEOUT_CYC=15, peripheral never acks -> after 15 cycles in REQ: err pulse, per_req=0, IDLE, no done; macro undefined -> per_req still high after 100 cycles.
